exec_retire_checker: RTL and testbench
======================================

# exec_retire_checker

Parametrised, synthesizable golden-model checker for the PDP-8 EXEC unit. It observes decoded opcodes, the EXEC memory request ports and retire-time architectural state (AC, Link, PC), predicts each result independently, and flags mismatches and protocol violations. It has explicit ports instead of hierarchical probes, a per-instruction tracking FSM, configurable compare latency, saturating error counters and an optional hang watchdog. It sits beside `instr_exec` in the unit-level and full-chip benches.

## Interface
- `DATA_WIDTH`, 12: word width.
- `ADDR_WIDTH`, 12: address width.
- `START_ADDR`, 'o200: golden PC after reset.
- `CMP_LAT`, 1: cycles from `retire` until `dut_acc`/`dut_link`/`dut_pc` are valid. Legal range 0..4.
- `ERR_CNT_W`, 16: error counter width.
- `WDOG_CYCLES`, 64: maximum number of cycles from instruction start to retire.
- `clk` in 1: free-running clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `stall` in 1: decoder stall. Its rising edge marks instruction start.
- `op_tad`, `op_and`, `op_isz`, `op_dca`, `op_jms`, `op_jmp`, `op_cla_cll` in 1 each: decoded opcode, at most one high. None high means unsupported/NOP.
- `mem_inst_addr` in ADDR_WIDTH: effective address.
- `rd_req` in 1, `rd_addr` in ADDR_WIDTH, `rd_data` in DATA_WIDTH: EXEC read port.
- `wr_req` in 1, `wr_addr` in ADDR_WIDTH, `wr_data` in DATA_WIDTH: EXEC write port.
- `retire` in 1: one-cycle pulse when EXEC leaves UNSTALL.
- `dut_acc` in DATA_WIDTH, `dut_link` in 1, `dut_pc` in ADDR_WIDTH: DUT state.
- `err_acc`, `err_link`, `err_pc`, `err_wr`, `err_proto`, `err_wdog` out 1 each: one-cycle error pulses.
- `err_any` out 1: sticky OR of all error pulses since reset.
- `err_count` out ERR_CNT_W: saturating count of cycles with any error pulse.
- `retire_count` out ERR_CNT_W: saturating count of retired instructions.

## Operation
- Opcodes are latched at instruction start (rising edge of `stall`).
- The FSM has four states:
  - IDLE: on start, go to OPERAND if the opcode is TAD, AND or ISZ. Go to WRITE if it is DCA or JMS. Otherwise go to RETIRE.
  - OPERAND: `rd_req` must be high for exactly 1 cycle and `rd_addr` must equal `mem_inst_addr`. Latch `rd_data` in the cycle after `rd_req`. Then go to WRITE for ISZ, or RETIRE for TAD/AND.
  - WRITE: on `wr_req`, compare `wr_data` (same cycle) against the golden write value and `wr_addr` against `mem_inst_addr`. Any difference raises `err_wr`. Then go to RETIRE.
  - RETIRE: on `retire`, update the golden state, push the expected values into the CMP_LAT delay line, and go to IDLE.
- Golden write values:
  - ISZ: (operand+1) mod 2^DATA_WIDTH.
  - DCA: golden AC.
  - JMS: (golden PC+1) mod 2^ADDR_WIDTH.
- Golden state updates:
  - TAD: {c,AC} = AC+operand, computed DATA_WIDTH+1 wide. Link is inverted if c=1. PC+1.
  - AND: AC &= operand. PC+1.
  - ISZ: PC+2 if the incremented value is 0, else PC+1.
  - DCA: AC=0. PC+1.
  - JMS: PC=addr+1.
  - JMP: PC=addr.
  - CLA_CLL: AC=0, Link=0. PC+1.
  - Other: PC+1.
  - All PC arithmetic wraps modulo 2^ADDR_WIDTH.
- Compare stage: CMP_LAT cycles after `retire`, pulse `err_acc`, `err_link` or `err_pc` for each field where the DUT differs from the delayed expected value.
- `err_proto` fires on any of these, and the FSM continues:
  - `rd_req` outside OPERAND, or held for 2 or more cycles.
  - `wr_req` outside WRITE.
  - `retire` in IDLE, OPERAND or WRITE (the FSM is forced to IDLE and the golden state is not updated).
  - A new start while not IDLE.
- Counters: `err_count` increments by 1 per cycle in which any error pulses, regardless of how many. Both counters stick at all-ones.

## Timing
- Reset (asynchronous):
  - FSM goes to IDLE.
  - Golden AC=0, Link=0, PC=START_ADDR.
  - All outputs are 0 and the delay line is cleared.
- A reset asserted mid-instruction discards the instruction without error.
- Read latency is fixed at 1 cycle: `rd_data` is sampled in the cycle after `rd_req`.
- Error pulses appear 1 cycle after the offending sample. The field compare appears CMP_LAT+1 cycles after `retire`.
- `retire` and the next start may fall in the same cycle. The retire is processed first and the new instruction is accepted; this is not a protocol error.
- Back-to-back retires are compared independently through the delay line.

## Configuration
- `EXEC_CHK_WATCHDOG_EN` defined: a cycle counter runs outside IDLE. If it reaches WDOG_CYCLES without a retire, `err_wdog` pulses once and the FSM returns to IDLE, leaving the golden state unchanged.
- Not defined: no watchdog logic, and `err_wdog` is tied to 0.

## Test plan
- Reset, CLA_CLL retire with `dut_acc`=0, `dut_link`=0, `dut_pc`='o201 -> no errors, `retire_count`=1.
- AC='o7777, TAD with operand 1 -> expected AC=0, Link inverted, PC+1. Drive `dut_link` wrong -> single `err_link` pulse, `err_count`=1, `err_any` sticky.
- ISZ with operand 'o7777 -> `wr_data` must be 0 and PC+2. ISZ with operand 5 -> `wr_data` must be 6 and PC+1.
- JMS to 'o300 with PC='o210 -> `wr_data`='o211, PC='o301. Drive `wr_data`='o210 -> `err_wr`.
- `rd_req` held 2 cycles during AND, then a `retire` during WRITE -> `err_proto` pulses, FSM forced to IDLE.
- With the macro defined and WDOG_CYCLES=8: start with no retire -> `err_wdog` pulses exactly once, 8 cycles after start. Without the macro, `err_wdog` stays 0.

Source files
------------

// File: rtl/exec_retire_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exec_retire_checker                                           |
// | Purpose  : Golden-model checker for the PDP-8 EXEC unit. Tracks each     |
// |            instruction from decoder-stall rising edge to retire, checks  |
// |            the EXEC read/write handshakes, predicts AC/Link/PC and       |
// |            compares them against the DUT CMP_LAT cycles after retire.    |
// | Ports    : clk, reset_n (async, active-low)                               |
// |            stall, op_* decoded opcode, mem_inst_addr effective address   |
// |            rd_req/rd_addr/rd_data, wr_req/wr_addr/wr_data EXEC ports     |
// |            retire pulse, dut_acc/dut_link/dut_pc DUT state               |
// |            err_acc/link/pc/wr/proto/wdog pulses, err_any sticky,         |
// |            err_count / retire_count saturating counters                  |
// | Options  : EXEC_CHK_WATCHDOG_EN enables the instruction hang watchdog.   |
// |            CMP_LAT legal range is 0..4.                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module exec_retire_checker #(
  parameter int                    DATA_WIDTH  = 12,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = ADDR_WIDTH'('o200),
  parameter int                    CMP_LAT     = 1,
  parameter int                    ERR_CNT_W   = 16,
  parameter int                    WDOG_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  op_tad,
  input  logic                  op_and,
  input  logic                  op_isz,
  input  logic                  op_dca,
  input  logic                  op_jms,
  input  logic                  op_jmp,
  input  logic                  op_cla_cll,
  input  logic [ADDR_WIDTH-1:0] mem_inst_addr,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  retire,
  input  logic [DATA_WIDTH-1:0] dut_acc,
  input  logic                  dut_link,
  input  logic [ADDR_WIDTH-1:0] dut_pc,
  output logic                  err_acc,
  output logic                  err_link,
  output logic                  err_pc,
  output logic                  err_wr,
  output logic                  err_proto,
  output logic                  err_wdog,
  output logic                  err_any,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [ERR_CNT_W-1:0]  retire_count
);

  // Bit positions inside the latched one-hot opcode vector.
  localparam int OP_TAD = 0;
  localparam int OP_AND = 1;
  localparam int OP_ISZ = 2;
  localparam int OP_DCA = 3;
  localparam int OP_JMS = 4;
  localparam int OP_JMP = 5;
  localparam int OP_CLA = 6;

  // Delay-line entry: {valid, acc, link, pc}.
  localparam int PW = 2 + DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPERAND = 2'd1,
    S_WRITE   = 2'd2,
    S_RETIRE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_stall_q;
  logic                  r_rd_q;
  logic [6:0]            r_op;
  logic [DATA_WIDTH-1:0] r_operand;
  logic [DATA_WIDTH-1:0] r_ac;
  logic                  r_link;
  logic [ADDR_WIDTH-1:0] r_pc;

  logic [6:0]            w_new_op;
  state_t                w_start_state;
  logic                  w_start;
  logic                  w_retire_ok;
  logic                  w_retire_bad;
  logic                  w_accept;
  logic                  w_start_bad;
  logic                  w_rd_bad;
  logic                  w_rd_latch;
  logic                  w_wr_bad;
  logic                  w_wr_err;
  logic                  w_wdog_fire;
  logic                  w_acc_err;
  logic                  w_link_err;
  logic                  w_pc_err;
  logic                  w_proto;
  logic                  w_any;

  logic [DATA_WIDTH:0]   w_tad_sum;
  logic [DATA_WIDTH-1:0] w_isz_val;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_pc_inc2;
  logic [DATA_WIDTH-1:0] w_gold_wr;
  logic [DATA_WIDTH-1:0] w_exp_acc;
  logic                  w_exp_link;
  logic [ADDR_WIDTH-1:0] w_exp_pc;

  logic [PW-1:0]         w_stage0;
  logic [PW-1:0]         w_cmp;
  logic                  w_cmp_vld;
  logic [DATA_WIDTH-1:0] w_cmp_acc;
  logic                  w_cmp_link;
  logic [ADDR_WIDTH-1:0] w_cmp_pc;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  assign w_new_op     = {op_cla_cll, op_jmp, op_jms, op_dca, op_isz, op_and, op_tad};
  assign w_start      = stall & ~r_stall_q;
  assign w_retire_ok  = (r_state == S_RETIRE) && retire;
  assign w_retire_bad = retire && (r_state != S_RETIRE);
  // A retire and the next start in the same cycle is legal: retire first.
  assign w_accept     = w_start && ((r_state == S_IDLE) || w_retire_ok);
  assign w_start_bad  = w_start && !w_accept;

  // Read must be a single-cycle pulse inside OPERAND at the effective address.
  assign w_rd_bad   = rd_req && ((r_state != S_OPERAND) || r_rd_q ||
                                 (rd_addr != mem_inst_addr));
  assign w_rd_latch = (r_state == S_OPERAND) && r_rd_q;
  assign w_wr_bad   = wr_req && (r_state != S_WRITE);
  assign w_wr_err   = wr_req && (r_state == S_WRITE) &&
                      ((wr_data != w_gold_wr) || (wr_addr != mem_inst_addr));

  always_comb begin
    w_start_state = S_RETIRE;
    if (op_tad || op_and || op_isz) begin
      w_start_state = S_OPERAND;
    end else if (op_dca || op_jms) begin
      w_start_state = S_WRITE;
    end
  end

  // ---------------------------------------------------------------------------
  // Golden model
  // ---------------------------------------------------------------------------
  assign w_tad_sum = {1'b0, r_ac} + {1'b0, r_operand};
  assign w_isz_val = r_operand + DATA_WIDTH'(1);
  assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
  assign w_pc_inc2 = r_pc + ADDR_WIDTH'(2);

  always_comb begin
    w_gold_wr = r_ac;  // DCA stores AC
    if (r_op[OP_ISZ]) begin
      w_gold_wr = w_isz_val;
    end else if (r_op[OP_JMS]) begin
      w_gold_wr = DATA_WIDTH'(w_pc_inc);
    end
  end

  always_comb begin
    w_exp_acc  = r_ac;
    w_exp_link = r_link;
    w_exp_pc   = w_pc_inc;
    if (r_op[OP_TAD]) begin
      w_exp_acc  = w_tad_sum[DATA_WIDTH-1:0];
      w_exp_link = r_link ^ w_tad_sum[DATA_WIDTH];
    end else if (r_op[OP_AND]) begin
      w_exp_acc = r_ac & r_operand;
    end else if (r_op[OP_ISZ]) begin
      if (w_isz_val == '0) begin
        w_exp_pc = w_pc_inc2;
      end
    end else if (r_op[OP_DCA]) begin
      w_exp_acc = '0;
    end else if (r_op[OP_JMS]) begin
      w_exp_pc = mem_inst_addr + ADDR_WIDTH'(1);
    end else if (r_op[OP_JMP]) begin
      w_exp_pc = mem_inst_addr;
    end else if (r_op[OP_CLA]) begin
      w_exp_acc  = '0;
      w_exp_link = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Expected-value delay line (stage 0 is the retire cycle itself)
  // ---------------------------------------------------------------------------
  assign w_stage0 = {w_retire_ok, w_exp_acc, w_exp_link, w_exp_pc};

  generate
    if (CMP_LAT == 0) begin : g_lat0
      assign w_cmp = w_stage0;
    end else begin : g_latn
      logic [PW-1:0] r_dly [CMP_LAT];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < CMP_LAT; i++) begin
            r_dly[i] <= '0;
          end
        end else begin
          r_dly[0] <= w_stage0;
          for (int i = 1; i < CMP_LAT; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end
      assign w_cmp = r_dly[CMP_LAT-1];
    end
  endgenerate

  assign {w_cmp_vld, w_cmp_acc, w_cmp_link, w_cmp_pc} = w_cmp;
  assign w_acc_err  = w_cmp_vld && (dut_acc  != w_cmp_acc);
  assign w_link_err = w_cmp_vld && (dut_link != w_cmp_link);
  assign w_pc_err   = w_cmp_vld && (dut_pc   != w_cmp_pc);

  // ---------------------------------------------------------------------------
  // Optional hang watchdog
  // ---------------------------------------------------------------------------
`ifdef EXEC_CHK_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog_cnt;

  // Counts cycles since start, the start cycle being 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog_cnt <= '0;
    end else if (w_accept) begin
      r_wdog_cnt <= WDOG_W'(1);
    end else if ((r_state != S_IDLE) && (r_wdog_cnt < WDOG_W'(WDOG_CYCLES))) begin
      r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
    end
  end

  assign w_wdog_fire = (r_state != S_IDLE) && !retire &&
                       (r_wdog_cnt >= WDOG_W'(WDOG_CYCLES));
`else
  assign w_wdog_fire = 1'b0;
`endif

  assign w_proto = w_rd_bad | w_wr_bad | w_retire_bad | w_start_bad;
  assign w_any   = w_acc_err | w_link_err | w_pc_err | w_wr_err | w_proto | w_wdog_fire;

  // ---------------------------------------------------------------------------
  // Tracking FSM, golden state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_stall_q    <= 1'b0;
      r_rd_q       <= 1'b0;
      r_op         <= '0;
      r_operand    <= '0;
      r_ac         <= '0;
      r_link       <= 1'b0;
      r_pc         <= START_ADDR;
      err_acc      <= 1'b0;
      err_link     <= 1'b0;
      err_pc       <= 1'b0;
      err_wr       <= 1'b0;
      err_proto    <= 1'b0;
      err_wdog     <= 1'b0;
      err_any      <= 1'b0;
      err_count    <= '0;
      retire_count <= '0;
    end else begin
      r_stall_q <= stall;
      r_rd_q    <= rd_req;

      if (w_accept) begin
        r_op    <= w_new_op;
        r_state <= w_start_state;
      end else if (w_wdog_fire || w_retire_bad) begin
        // Abandon the instruction; golden state stays as it was.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_OPERAND: begin
            if (w_rd_latch) begin
              r_operand <= rd_data;
              r_state   <= r_op[OP_ISZ] ? S_WRITE : S_RETIRE;
            end
          end
          S_WRITE: begin
            if (wr_req) begin
              r_state <= S_RETIRE;
            end
          end
          S_RETIRE: begin
            if (retire) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      if (w_retire_ok) begin
        r_ac   <= w_exp_acc;
        r_link <= w_exp_link;
        r_pc   <= w_exp_pc;
        if (retire_count != '1) begin
          retire_count <= retire_count + ERR_CNT_W'(1);
        end
      end

      err_acc   <= w_acc_err;
      err_link  <= w_link_err;
      err_pc    <= w_pc_err;
      err_wr    <= w_wr_err;
      err_proto <= w_proto;
      err_wdog  <= w_wdog_fire;
      err_any   <= err_any | w_any;
      if (w_any && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_retire_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_exec_retire_checker                                        |
// | Purpose  : Directed self-checking bench for exec_retire_checker.         |
// |            Inputs change and outputs are sampled on the falling edge.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_exec_retire_checker;

  localparam int DW = 12;
  localparam int AW = 12;

  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_TAD = 7'b0000001;
  localparam logic [6:0] OP_AND = 7'b0000010;
  localparam logic [6:0] OP_ISZ = 7'b0000100;
  localparam logic [6:0] OP_DCA = 7'b0001000;
  localparam logic [6:0] OP_JMS = 7'b0010000;
  localparam logic [6:0] OP_JMP = 7'b0100000;
  localparam logic [6:0] OP_CLA = 7'b1000000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          stall = 1'b0;
  logic          op_tad = 1'b0, op_and = 1'b0, op_isz = 1'b0, op_dca = 1'b0;
  logic          op_jms = 1'b0, op_jmp = 1'b0, op_cla_cll = 1'b0;
  logic [AW-1:0] mem_inst_addr = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          retire = 1'b0;
  logic [DW-1:0] dut_acc = '0;
  logic          dut_link = 1'b0;
  logic [AW-1:0] dut_pc = '0;
  logic          err_acc, err_link, err_pc, err_wr, err_proto, err_wdog, err_any;
  logic [15:0]   err_count, retire_count;

  int n_cmp  = 0;
  int n_fail = 0;

  exec_retire_checker #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .START_ADDR (12'o200),
    .CMP_LAT    (1),
    .ERR_CNT_W  (16),
    .WDOG_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .op_tad       (op_tad),
    .op_and       (op_and),
    .op_isz       (op_isz),
    .op_dca       (op_dca),
    .op_jms       (op_jms),
    .op_jmp       (op_jmp),
    .op_cla_cll   (op_cla_cll),
    .mem_inst_addr(mem_inst_addr),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .retire       (retire),
    .dut_acc      (dut_acc),
    .dut_link     (dut_link),
    .dut_pc       (dut_pc),
    .err_acc      (err_acc),
    .err_link     (err_link),
    .err_pc       (err_pc),
    .err_wr       (err_wr),
    .err_proto    (err_proto),
    .err_wdog     (err_wdog),
    .err_any      (err_any),
    .err_count    (err_count),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'o%0o expected 'o%0o", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [6:0] op);
    {op_cla_cll, op_jmp, op_jms, op_dca, op_isz, op_and, op_tad} = op;
  endtask

  // Raise stall for one cycle with the opcode; opcode lines drop afterwards.
  task automatic start_instr(input logic [6:0] op, input logic [AW-1:0] addr);
    stall = 1'b1;
    set_op(op);
    mem_inst_addr = addr;
    tick();
    stall = 1'b0;
    set_op(OP_NOP);
  endtask

  // One-cycle read request, data presented in the following cycle.
  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    rd_req  = 1'b1;
    rd_addr = addr;
    rd_data = ~data;
    tick();
    rd_req  = 1'b0;
    rd_data = data;
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_req  = 1'b0;
  endtask

  // DUT state is held until the next call, covering the compare cycle.
  task automatic do_retire(input logic [DW-1:0] acc, input logic lnk, input logic [AW-1:0] pc);
    retire   = 1'b1;
    dut_acc  = acc;
    dut_link = lnk;
    dut_pc   = pc;
    tick();
    retire   = 1'b0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    tick();
    tick();
    chk("reset_err_any", err_any, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_retire_count", retire_count, 0);
    chk("reset_err_proto", err_proto, 0);
    reset_n = 1'b1;
    tick();

    // CLA_CLL from reset: AC=0 L=0 PC='o201
    start_instr(OP_CLA, 12'o000);
    do_retire(12'o0000, 1'b0, 12'o201);
    chk("cla_retire_count", retire_count, 1);
    chk("cla_proto", err_proto, 0);
    tick();
    chk("cla_acc", err_acc, 0);
    chk("cla_link", err_link, 0);
    chk("cla_pc", err_pc, 0);

    // TAD 'o7777 into AC=0: AC='o7777, no carry, PC='o202
    start_instr(OP_TAD, 12'o050);
    do_read(12'o050, 12'o7777);
    do_retire(12'o7777, 1'b0, 12'o202);
    tick();
    chk("tad_fill_acc", err_acc, 0);
    chk("tad_fill_link", err_link, 0);

    // TAD 1 into 'o7777: AC=0, Link flips to 1, PC='o203; DUT link driven wrong
    start_instr(OP_TAD, 12'o051);
    do_read(12'o051, 12'o0001);
    do_retire(12'o0000, 1'b0, 12'o203);
    chk("tad_link_early", err_link, 0);
    tick();
    chk("tad_link_pulse", err_link, 1);
    chk("tad_carry_acc", err_acc, 0);
    chk("tad_carry_pc", err_pc, 0);
    chk("tad_err_count", err_count, 1);
    chk("tad_err_any", err_any, 1);
    tick();
    chk("tad_link_single", err_link, 0);
    chk("tad_err_any_sticky", err_any, 1);

    // ISZ 'o7777: write 0, skip -> PC='o205
    start_instr(OP_ISZ, 12'o060);
    do_read(12'o060, 12'o7777);
    do_write(12'o060, 12'o0000);
    chk("isz_wrap_wr", err_wr, 0);
    chk("isz_wrap_proto", err_proto, 0);
    do_retire(12'o0000, 1'b1, 12'o205);
    tick();
    chk("isz_wrap_pc", err_pc, 0);

    // ISZ 5: write 6, no skip -> PC='o206
    start_instr(OP_ISZ, 12'o061);
    do_read(12'o061, 12'o0005);
    do_write(12'o061, 12'o0006);
    chk("isz5_wr", err_wr, 0);
    do_retire(12'o0000, 1'b1, 12'o206);
    tick();
    chk("isz5_pc", err_pc, 0);

    // JMP 'o210
    start_instr(OP_JMP, 12'o210);
    do_retire(12'o0000, 1'b1, 12'o210);
    tick();
    chk("jmp_pc", err_pc, 0);

    // JMS 'o300 from PC='o210: golden write 'o211, driven 'o210; PC='o301
    start_instr(OP_JMS, 12'o300);
    do_write(12'o300, 12'o0210);
    chk("jms_wr_err", err_wr, 1);
    chk("jms_err_count", err_count, 2);
    do_retire(12'o0000, 1'b1, 12'o301);
    chk("jms_wr_single", err_wr, 0);
    tick();
    chk("jms_pc", err_pc, 0);

    // TAD 'o1234: AC='o1234, L=1, PC='o302
    start_instr(OP_TAD, 12'o052);
    do_read(12'o052, 12'o1234);
    do_retire(12'o1234, 1'b1, 12'o302);
    tick();
    chk("tad2_acc", err_acc, 0);

    // AND 'o0707 with rd_req held two cycles: AC='o0204, PC='o303
    start_instr(OP_AND, 12'o070);
    rd_req  = 1'b1;
    rd_addr = 12'o070;
    rd_data = 12'o7777;
    tick();
    rd_data = 12'o0707;
    tick();
    rd_req = 1'b0;
    chk("and_rd_held_proto", err_proto, 1);
    chk("and_err_count", err_count, 3);
    do_retire(12'o0204, 1'b1, 12'o303);
    chk("and_proto_single", err_proto, 0);
    chk("and_retire_count", retire_count, 9);
    tick();
    chk("and_acc", err_acc, 0);
    chk("and_pc", err_pc, 0);

    // DCA with retire during WRITE: forced to IDLE, golden state untouched
    start_instr(OP_DCA, 12'o100);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("dca_early_retire_proto", err_proto, 1);
    chk("dca_early_retire_count", retire_count, 9);
    chk("dca_early_err_count", err_count, 4);
    start_instr(OP_DCA, 12'o101);
    chk("dca_restart_proto", err_proto, 0);
    do_write(12'o101, 12'o0204);
    chk("dca_wr", err_wr, 0);
    do_retire(12'o0000, 1'b1, 12'o304);
    chk("dca_retire_count", retire_count, 10);
    tick();
    chk("dca_acc", err_acc, 0);
    chk("dca_pc", err_pc, 0);

    // Write request while IDLE
    do_write(12'o101, 12'o0000);
    chk("idle_wr_proto", err_proto, 1);
    chk("idle_wr_no_wr_err", err_wr, 0);
    chk("idle_wr_err_count", err_count, 5);

    // NOP retire coinciding with CLA_CLL start
    start_instr(OP_NOP, 12'o000);
    tick();
    retire   = 1'b1;
    dut_acc  = 12'o0000;
    dut_link = 1'b1;
    dut_pc   = 12'o305;
    stall    = 1'b1;
    set_op(OP_CLA);
    tick();
    retire = 1'b0;
    stall  = 1'b0;
    set_op(OP_NOP);
    chk("overlap_proto", err_proto, 0);
    chk("overlap_retire_count", retire_count, 11);
    tick();
    chk("nop_pc", err_pc, 0);
    do_retire(12'o0000, 1'b0, 12'o306);
    chk("overlap_cla_count", retire_count, 12);
    tick();
    chk("overlap_cla_link", err_link, 0);
    chk("overlap_cla_pc", err_pc, 0);

    // Instruction that never retires
    start_instr(OP_NOP, 12'o000);
`ifdef EXEC_CHK_WATCHDOG_EN
    for (int i = 1; i <= 8; i++) begin
      chk("wdog_quiet", err_wdog, 0);
      tick();
    end
    chk("wdog_fire", err_wdog, 1);
    chk("wdog_err_count", err_count, 6);
    tick();
    chk("wdog_single", err_wdog, 0);
    start_instr(OP_NOP, 12'o000);
    chk("wdog_idle_restart", err_proto, 0);
`else
    for (int i = 1; i <= 10; i++) begin
      chk("wdog_disabled", err_wdog, 0);
      tick();
    end
`endif
    do_retire(12'o0000, 1'b0, 12'o307);
    chk("final_retire_count", retire_count, 13);
    tick();
    chk("final_pc", err_pc, 0);
`ifdef EXEC_CHK_WATCHDOG_EN
    chk("final_err_count", err_count, 6);
`else
    chk("final_err_count", err_count, 5);
`endif
    chk("final_err_any", err_any, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
